boid_frame_scheduler: RTL and testbench

Sequencer for the boid display frame buffer. On a refresh request it issues a one-cycle buffer-clear/switch pulse and then walks every BPU in turn. For each boid it drives the read-select onto the shared boid position bus and converts the returned (x, y) into a pixel write into the display RAM. It sits between the CPU refresh register / VGA screen-end strobe, the BPU array, and the resettable display RAM, and replaces ad-hoc refresh logic in the top level.

---
 rtl/boid_frame_scheduler_if.sv | 23 ++
 rtl/boid_frame_scheduler.sv | 138 +++++++++++++
 tb/tb_boid_frame_scheduler.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/boid_frame_scheduler_if.sv
// Boid position bus and display RAM write port of the frame scheduler.
// master: the scheduler side; slave: the BPU array / display RAM side.
interface boid_frame_scheduler_if #(
  parameter int SEL_W  = 6,
  parameter int ADDR_W = 19
);
  logic [9:0]        boid_x;
  logic [8:0]        boid_y;
  logic [SEL_W-1:0]  boid_sel;
  logic              disp_we;
  logic [ADDR_W-1:0] disp_addr;
  logic              ram_switch;

  modport master (
    input  boid_x, boid_y,
    output boid_sel, disp_we, disp_addr, ram_switch
  );

  modport slave (
    output boid_x, boid_y,
    input  boid_sel, disp_we, disp_addr, ram_switch
  );
endinterface

// File: rtl/boid_frame_scheduler.sv
// Boid display frame sequencer: on a refresh request pulses ram_switch, then
// scans every BPU once and turns each on-screen (x, y) into a display RAM
// write at x + 640*y.
// Optional macro BOID_FRAME_DIV_EN: divide screen_end requests by FRAME_DIV.
module boid_frame_scheduler #(
  parameter int NUM_BOIDS = 64,
  parameter int SEL_W     = $clog2(NUM_BOIDS),
  parameter int ADDR_W    = 19,
  parameter int FRAME_DIV = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          refresh_req,
  input  logic                          screen_end,
  input  logic                          src_sel,
  input  logic                          hold,
  boid_frame_scheduler_if.master        bus,
  output logic                          busy,
  output logic [15:0]                   frame_count,
  output logic [7:0]                    overrun_count
);

  if (NUM_BOIDS < 2 || NUM_BOIDS > 256 || (NUM_BOIDS & (NUM_BOIDS - 1)) != 0)
    $error("NUM_BOIDS must be a power of two in 2..256");
  if (FRAME_DIV < 1)
    $error("FRAME_DIV must be at least 1");

  typedef enum logic [1:0] {IDLE, SWITCH, SCAN, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  idx;
  logic              pending;
  logic              rr_prev, se_prev;
  logic              rr_edge, se_edge, se_req, req;
  logic              last, in_scan, on_screen;
  logic [ADDR_W-1:0] addr_calc;

  // Each source keeps its own history, so flipping src_sel never fakes an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_prev <= 1'b0;
      se_prev <= 1'b0;
    end else begin
      rr_prev <= refresh_req;
      se_prev <= screen_end;
    end
  end

  assign rr_edge = refresh_req & ~rr_prev;
  assign se_edge = screen_end & ~se_prev;

`ifdef BOID_FRAME_DIV_EN
  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap;

  assign div_wrap = (div_cnt == DIV_W'(FRAME_DIV - 1));

  // Screen-end divider; keeps counting while hold is asserted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      div_cnt <= '0;
    else if (src_sel && se_edge)
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
  end

  assign se_req = se_edge & div_wrap;
`else
  assign se_req = se_edge;
`endif

  assign req       = ~hold & (src_sel ? se_req : rr_edge);
  assign last      = (idx == SEL_W'(NUM_BOIDS - 1));
  assign in_scan   = (state == SCAN);
  assign on_screen = (bus.boid_x < 10'd640) && (bus.boid_y < 9'd480);
  assign addr_calc = ADDR_W'(bus.boid_x) + (ADDR_W'(bus.boid_y) << 9)
                   + (ADDR_W'(bus.boid_y) << 7);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a request landing in FLUSH chains straight into SWITCH.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (req) state_nxt = SWITCH;
      SWITCH: state_nxt = SCAN;
      SCAN:   if (last) state_nxt = FLUSH;
      FLUSH:  state_nxt = (pending || req) ? SWITCH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs.
  always_comb begin
    bus.ram_switch = (state == SWITCH);
    bus.boid_sel   = in_scan ? idx : '0;
    busy           = (state != IDLE);
  end

  // Scan index, frame counter, pending flag and saturating overrun counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx           <= '0;
      pending       <= 1'b0;
      frame_count   <= '0;
      overrun_count <= '0;
    end else begin
      idx <= (in_scan && !last) ? idx + 1'b1 : '0;
      if (state == FLUSH) begin
        // The old pending request is consumed here; a fresh one replaces it.
        pending     <= pending & req;
        frame_count <= frame_count + 16'd1;
      end else if (state != IDLE && req) begin
        if (pending) begin
          if (overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
        end else begin
          pending <= 1'b1;
        end
      end
    end
  end

  // Registered pixel write; off-screen boids leave the address untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.disp_we   <= 1'b0;
      bus.disp_addr <= '0;
    end else begin
      bus.disp_we <= in_scan & on_screen;
      if (in_scan && on_screen) bus.disp_addr <= addr_calc;
    end
  end

endmodule

// File: tb/tb_boid_frame_scheduler.sv
// Directed bench for boid_frame_scheduler with a combinational BPU array model.
module tb_boid_frame_scheduler;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        refresh_req = 1'b0;
  logic        screen_end = 1'b0;
  logic        src_sel = 1'b0;
  logic        hold = 1'b0;
  logic        busy;
  logic [15:0] frame_count;
  logic [7:0]  overrun_count;

  boid_frame_scheduler_if #(.SEL_W(6), .ADDR_W(19)) bus ();

  boid_frame_scheduler #(.NUM_BOIDS(64), .SEL_W(6), .ADDR_W(19), .FRAME_DIV(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .refresh_req   (refresh_req),
    .screen_end    (screen_end),
    .src_sel       (src_sel),
    .hold          (hold),
    .bus           (bus),
    .busy          (busy),
    .frame_count   (frame_count),
    .overrun_count (overrun_count)
  );

  always #5 clock = ~clock;

  logic [9:0] bx [64];
  logic [8:0] by [64];
  assign bus.boid_x = bx[bus.boid_sel];
  assign bus.boid_y = by[bus.boid_sel];

  int checks = 0;
  int failures = 0;

  // Monitor: cumulative activity and the address written for each boid.
  int we_total = 0, sw_total = 0, busy_total = 0, coll_total = 0;
  int prev_sel = 0;
  int wr_addr [64];
  bit seen [64];

  always @(negedge clock) begin
    if (bus.ram_switch) begin
      sw_total <= sw_total + 1;
      for (int i = 0; i < 64; i++) seen[i] <= 1'b0;
    end
    if (bus.disp_we) begin
      we_total          <= we_total + 1;
      wr_addr[prev_sel] <= int'(bus.disp_addr);
      seen[prev_sel]    <= 1'b1;
    end
    if (bus.ram_switch && bus.disp_we) coll_total <= coll_total + 1;
    if (busy) busy_total <= busy_total + 1;
    prev_sel <= int'(bus.boid_sel);
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rise_refresh();
    refresh_req = 1'b0;
    step();
    refresh_req = 1'b1;
    step();
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      step();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  function automatic int addr_bad();
    int bad = 0;
    for (int i = 0; i < 64; i++)
      if (seen[i] && wr_addr[i] != int'(bx[i]) + 640 * int'(by[i])) bad++;
    return bad;
  endfunction

  function automatic int seen_count();
    int c = 0;
    for (int i = 0; i < 64; i++) if (seen[i]) c++;
    return c;
  endfunction

  function automatic void default_boids();
    for (int i = 0; i < 64; i++) begin
      bx[i] = 10'(i);
      by[i] = 9'(2 * i);
    end
  endfunction

  int s_we, s_sw, s_busy, s_fc, n, exp_frames;

  task automatic snap();
    s_we   = we_total;
    s_sw   = sw_total;
    s_busy = busy_total;
    s_fc   = int'(frame_count);
  endtask

  initial begin
    default_boids();
    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_sel", bus.boid_sel, 0);
    chk("rst_we", bus.disp_we, 0);
    chk("rst_addr", bus.disp_addr, 0);
    chk("rst_switch", bus.ram_switch, 0);
    chk("rst_frames", frame_count, 0);
    chk("rst_overrun", overrun_count, 0);

    // Basic frame: boid i at (i, 2i) -> addr i + 1280*i.
    snap();
    rise_refresh();
    wait_idle("basic_idle", 200);
    chk("basic_switch", sw_total - s_sw, 1);
    chk("basic_we", we_total - s_we, 64);
    chk("basic_busy", busy_total - s_busy, 66);
    chk("basic_frames", frame_count, 1);
    chk("basic_addr0", wr_addr[0], 0);
    chk("basic_addr10", wr_addr[10], 12810);
    chk("basic_addr63", wr_addr[63], 80703);
    chk("basic_addr_all", addr_bad(), 0);
    chk("basic_collide", coll_total, 0);

    // Off-screen skip and far-corner boundary.
    bx[5] = 10'd640; by[5] = 9'd10;
    bx[6] = 10'd3;   by[6] = 9'd480;
    bx[63] = 10'd639; by[63] = 9'd479;
    snap();
    rise_refresh();
    wait_idle("skip_idle", 200);
    chk("skip_we", we_total - s_we, 62);
    chk("skip_seen5", seen[5], 0);
    chk("skip_seen6", seen[6], 0);
    chk("skip_addr63", wr_addr[63], 307199);
    chk("skip_addr_all", addr_bad(), 0);
    chk("skip_frames", frame_count, 2);
    default_boids();

    // Three edges in one frame: two chained frames, one overrun.
    snap();
    rise_refresh();
    repeat (5) step();
    refresh_req = 1'b0; step(); refresh_req = 1'b1; step();
    refresh_req = 1'b0; step(); refresh_req = 1'b1; step();
    wait_idle("pend_idle", 400);
    chk("pend_switch", sw_total - s_sw, 2);
    chk("pend_frames", int'(frame_count) - s_fc, 2);
    chk("pend_busy", busy_total - s_busy, 132);
    chk("pend_overrun", overrun_count, 1);
    chk("pend_collide", coll_total, 0);

    // Flood of edges: overrun saturates.
    for (int i = 0; i < 301; i++) begin
      refresh_req = 1'b0; step();
      refresh_req = 1'b1; step();
    end
    wait_idle("flood_idle", 400);
    chk("flood_overrun", overrun_count, 255);

    // Reset mid-scan at boid 20.
    rise_refresh();
    n = 0;
    while (bus.boid_sel != 6'd20 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("mid_reach_sel20", bus.boid_sel, 20);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sel", bus.boid_sel, 0);
    chk("mid_rst_we", bus.disp_we, 0);
    chk("mid_rst_addr", bus.disp_addr, 0);
    chk("mid_rst_switch", bus.ram_switch, 0);
    chk("mid_rst_frames", frame_count, 0);
    chk("mid_rst_overrun", overrun_count, 0);
    step();
    reset = 1'b0;
    snap();
    rise_refresh();
    wait_idle("rec_idle", 200);
    chk("rec_we", we_total - s_we, 64);
    chk("rec_seen", seen_count(), 64);
    chk("rec_addr_all", addr_bad(), 0);
    chk("rec_frames", frame_count, 1);

    // Hold while idle: nothing starts.
    hold = 1'b1;
    snap();
    rise_refresh();
    repeat (5) step();
    chk("hold_busy", busy_total - s_busy, 0);
    chk("hold_switch", sw_total - s_sw, 0);
    hold = 1'b0;
    repeat (3) step();
    chk("hold_release_busy", busy_total - s_busy, 0);

    // Hold raised mid-frame: frame completes, extra edges ignored.
    snap();
    rise_refresh();
    repeat (10) step();
    hold = 1'b1;
    refresh_req = 1'b0; step(); refresh_req = 1'b1; step();
    refresh_req = 1'b0; step(); refresh_req = 1'b1; step();
    wait_idle("holdmid_idle", 200);
    chk("holdmid_frames", int'(frame_count) - s_fc, 1);
    chk("holdmid_switch", sw_total - s_sw, 1);
    chk("holdmid_we", we_total - s_we, 64);
    chk("holdmid_overrun", overrun_count, 0);
    hold = 1'b0;

    // Switching source to a level that is already high creates no edge.
    snap();
    src_sel = 1'b1;
    step();
    src_sel = 1'b0;
    repeat (4) step();
    chk("srcswap_busy", busy_total - s_busy, 0);

    // Screen-end source, 48 pulses spaced 72 cycles.
`ifdef BOID_FRAME_DIV_EN
    exp_frames = 3;
`else
    exp_frames = 48;
`endif
    src_sel = 1'b1;
    snap();
    for (int i = 0; i < 48; i++) begin
      screen_end = 1'b1; step();
      screen_end = 1'b0;
      repeat (71) step();
    end
    wait_idle("div_idle", 200);
    chk("div_frames", int'(frame_count) - s_fc, exp_frames);
    chk("div_switch", sw_total - s_sw, exp_frames);
    chk("div_collide", coll_total, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
